// File: rtl/ring_inject_arbiter.sv
// Ring injection arbiter: round-robin with lock bursts and one grant in flight at a time.
// Optional starvation promotion is compiled in with RING_ARB_STARVATION_EN.
package ring_arb_pkg;
    typedef logic [31:0] ring_packet_t;
endpackage

// state  | meaning
// IDLE   | round-robin among requesters, starting after the last winner
// LOCKED | owner_q keeps the ring while it requests, up to LOCK_LIMIT grants
module ring_inject_arbiter
    import ring_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_LIMIT   = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic         [NUM_REQ-1:0] req,
    input  logic         [NUM_REQ-1:0] lock,
    input  ring_packet_t [NUM_REQ-1:0] pkt_in,
    output logic         [NUM_REQ-1:0] gnt,
    input  logic                       fifo_full,
    input  logic                       fifo_almost_full,
    output logic                       fifo_wrreq,
    output ring_packet_t               fifo_data,
    output logic         [NUM_REQ-1:0] starve_flag
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         lock_cnt_q, lock_cnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_last_q, rr_last_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               fifo_wrreq_q, fifo_wrreq_d;
    ring_packet_t       fifo_data_q, fifo_data_d;

    logic               arb_ok;
    logic               rr_found;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   rr_cand;
    logic               st_found;
    logic [IDX_W-1:0]   st_idx;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               owner_grant;
    logic [4:0]         lock_next;

    // A grant cycle is a handshake: the next arbitration waits for it to retire.
    assign arb_ok = enable && !fifo_full && !(fifo_wrreq_q && fifo_almost_full)
                    && (gnt_q == '0);

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_cand = IDX_W'((int'(rr_last_q) + k) % NUM_REQ);
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

`ifdef RING_ARB_STARVATION_EN
    logic [NUM_REQ-1:0][7:0] wait_q, wait_d;
    logic [NUM_REQ-1:0]      promoted;

    always_comb begin
        wait_d = wait_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req[i] || gnt_d[i] || gnt_q[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != 8'hFF) begin
                wait_d[i] = wait_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    always_comb begin
        starve_flag = '0;
        st_found    = 1'b0;
        st_idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starve_flag[i] = (wait_q[i] >= 8'(STARVE_LIMIT));
        end
        promoted = starve_flag & req;
        // Descending scan so the lowest promoted index is the one left standing.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (promoted[i]) begin
                st_found = 1'b1;
                st_idx   = IDX_W'(i);
            end
        end
    end
`else
    assign starve_flag = '0;
    assign st_found    = 1'b0;
    assign st_idx      = '0;
`endif

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        owner_d      = owner_q;
        rr_last_d    = rr_last_q;
        gnt_d        = '0;
        fifo_wrreq_d = 1'b0;
        fifo_data_d  = fifo_data_q;
        win_valid    = 1'b0;
        win_idx      = '0;
        owner_grant  = 1'b0;
        lock_next    = {1'b0, lock_cnt_q} + 5'd1;

        if (arb_ok) begin
            if (st_found) begin
                win_valid = 1'b1;
                win_idx   = st_idx;
            end else if (state_q == ST_LOCKED && req[owner_q]) begin
                win_valid   = 1'b1;
                win_idx     = owner_q;
                owner_grant = 1'b1;
            end else if (rr_found) begin
                win_valid = 1'b1;
                win_idx   = rr_idx;
            end

            if (win_valid) begin
                gnt_d[win_idx] = 1'b1;
                fifo_wrreq_d   = 1'b1;
                fifo_data_d    = pkt_in[win_idx];
                rr_last_d      = win_idx;
                if (owner_grant) begin
                    if (!lock[win_idx] || lock_next >= 5'(LOCK_LIMIT)) begin
                        state_d    = ST_IDLE;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_next[3:0];
                    end
                end else if (lock[win_idx] && LOCK_LIMIT > 1) begin
                    state_d    = ST_LOCKED;
                    owner_d    = win_idx;
                    lock_cnt_d = 4'd1;
                end else begin
                    // Also covers a promoted requester preempting a lock owner.
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end
            end else begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            lock_cnt_q   <= '0;
            owner_q      <= '0;
            rr_last_q    <= IDX_W'(NUM_REQ - 1);
            gnt_q        <= '0;
            fifo_wrreq_q <= 1'b0;
            fifo_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            owner_q      <= owner_d;
            rr_last_q    <= rr_last_d;
            gnt_q        <= gnt_d;
            fifo_wrreq_q <= fifo_wrreq_d;
            fifo_data_q  <= fifo_data_d;
        end
    end

    assign gnt        = gnt_q;
    assign fifo_wrreq = fifo_wrreq_q;
    assign fifo_data  = fifo_data_q;

endmodule

// File: tb/tb_ring_inject_arbiter.sv
// Scoreboard bench for ring_inject_arbiter: directed scenarios push expected writes,
// a monitor pops and compares on every FIFO write.
module tb_ring_inject_arbiter;
    import ring_arb_pkg::*;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               enable = 1'b0;
    logic               fifo_full = 1'b0;
    logic               fifo_almost_full = 1'b0;
    logic [3:0]         req = '0;
    logic [3:0]         lock = '0;
    ring_packet_t [3:0] pkt_in;
    logic [3:0]         gnt;
    logic [3:0]         starve_flag;
    logic               fifo_wrreq;
    ring_packet_t       fifo_data;

    int total = 0;
    int bad = 0;
    int n_writes = 0;
    int w0;
    ring_packet_t last_exp_data = '0;

    typedef struct packed {
        logic [3:0]   gnt;
        ring_packet_t data;
    } exp_t;
    exp_t exp_q[$];

    ring_inject_arbiter #(
        .NUM_REQ(4),
        .LOCK_LIMIT(4),
        .STARVE_LIMIT(16)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .req(req),
        .lock(lock),
        .pkt_in(pkt_in),
        .gnt(gnt),
        .fifo_full(fifo_full),
        .fifo_almost_full(fifo_almost_full),
        .fifo_wrreq(fifo_wrreq),
        .fifo_data(fifo_data),
        .starve_flag(starve_flag)
    );

    always #5 clock = ~clock;

    function automatic ring_packet_t mk_pkt(input int tag, input int i);
        return {8'(tag), 8'hA5, 8'(i * 17), 8'(i)};
    endfunction

    task automatic set_pkts(input int tag);
        for (int i = 0; i < 4; i++) pkt_in[i] = mk_pkt(tag, i);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_gnt(input int tag, input int i);
        exp_t e;
        e.gnt  = 4'(1 << i);
        e.data = mk_pkt(tag, i);
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (fifo_wrreq) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got gnt %b data %h expected no write at %0t",
                         gnt, fifo_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("gnt", 32'(gnt), 32'(e.gnt));
                check("data", fifo_data, e.data);
                last_exp_data = e.data;
            end
        end else begin
            check("idle_gnt", 32'(gnt), 32'd0);
            check("hold_data", fifo_data, last_exp_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        set_pkts(0);
        step(2);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_wrreq", 32'(fifo_wrreq), 32'd0);
        check("rst_data", fifo_data, 32'd0);
        check("rst_starve", 32'(starve_flag), 32'd0);
        reset_n = 1'b1;
        enable  = 1'b1;

        // All four requesting, no lock: one grant every other cycle in index order.
        set_pkts(1);
        req  = 4'b1111;
        lock = 4'b0000;
        for (int i = 0; i < 5; i++) expect_gnt(1, i % 4);
        w0 = n_writes;
        step(9);
        req = '0;
        step(2);
        check("rr_writes", 32'(n_writes - w0), 32'd5);

        // Locked requester 2 gets LOCK_LIMIT grants, then 0 gets its turn.
        set_pkts(2);
        req  = 4'b0101;
        lock = 4'b0100;
        for (int i = 0; i < 4; i++) expect_gnt(2, 2);
        expect_gnt(2, 0);
        w0 = n_writes;
        step(9);
        req  = '0;
        lock = '0;
        step(2);
        check("lock_writes", 32'(n_writes - w0), 32'd5);

        // Almost-full: first grant allowed, none on the cycle with a write in flight.
        set_pkts(3);
        fifo_almost_full = 1'b1;
        req = 4'b0011;
        expect_gnt(3, 1);
        expect_gnt(3, 0);
        w0 = n_writes;
        step(3);
        req = '0;
        step(1);
        fifo_almost_full = 1'b0;
        step(1);
        check("afull_writes", 32'(n_writes - w0), 32'd2);

        // Full for 10 cycles while locked: no writes, lock state and count preserved.
        set_pkts(4);
        req  = 4'b0010;
        lock = 4'b0010;
        expect_gnt(4, 1);
        step(1);
        fifo_full = 1'b1;
        w0 = n_writes;
        step(10);
        check("full_writes", 32'(n_writes - w0), 32'd0);
        fifo_full = 1'b0;
        req = 4'b1010;
        for (int i = 0; i < 3; i++) expect_gnt(4, 1);
        expect_gnt(4, 3);
        w0 = n_writes;
        step(7);
        req  = '0;
        lock = '0;
        step(2);
        check("post_full_writes", 32'(n_writes - w0), 32'd4);

        // Enable low blocks grants.
        set_pkts(5);
        enable = 1'b0;
        req = 4'b0001;
        w0 = n_writes;
        step(3);
        check("disabled_writes", 32'(n_writes - w0), 32'd0);
        enable = 1'b1;
        expect_gnt(5, 0);
        step(1);
        req = '0;
        step(2);

        // Requester 1 locked, requester 3 waits behind a full FIFO.
        set_pkts(6);
        req  = 4'b0010;
        lock = 4'b0010;
        expect_gnt(6, 1);
        step(1);
        req = 4'b1000;
        fifo_full = 1'b1;
`ifdef RING_ARB_STARVATION_EN
        step(15);
        check("starve_15", 32'(starve_flag), 32'd0);
        step(1);
        check("starve_16", 32'(starve_flag), 32'h8);
        fifo_full = 1'b0;
        req = 4'b1011;
        expect_gnt(6, 3);
        expect_gnt(6, 0);
        step(1);
        check("starve_clear", 32'(starve_flag), 32'd0);
        step(2);
`else
        step(16);
        check("starve_off", 32'(starve_flag), 32'd0);
        fifo_full = 1'b0;
        req = 4'b1011;
        for (int i = 0; i < 3; i++) expect_gnt(6, 1);
        expect_gnt(6, 3);
        expect_gnt(6, 0);
        step(9);
`endif
        req  = '0;
        lock = '0;
        step(2);

        // Reset mid-lock with gnt high: outputs clear at once, lock is forgotten.
        set_pkts(7);
        req  = 4'b0100;
        lock = 4'b0100;
        expect_gnt(7, 2);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        last_exp_data = '0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'd0);
        check("async_rst_wrreq", 32'(fifo_wrreq), 32'd0);
        check("async_rst_data", fifo_data, 32'd0);
        @(negedge clock);
        req  = 4'b0110;
        lock = 4'b0110;
        step(2);
        reset_n = 1'b1;
        expect_gnt(7, 1);
        step(1);
        req  = '0;
        lock = '0;
        step(3);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ring_inject_arbiter.md
RING_INJECT_ARBITER -- requirements
Module: ring_inject_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of local requesters (2..8).
REQ-002 SHALL have parameter LOCK_LIMIT, default 4, max consecutive grants to one locked requester (1..15).
REQ-003 SHALL have parameter STARVE_LIMIT, default 16, wait cycles before a requester is promoted (2..255).
REQ-004 SHALL have port clock  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  ring enable; no new grants while low.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester request, held until granted.
REQ-008 SHALL have port lock  input  NUM_REQ  per-requester "keep grant for next packet", qualified by req.
REQ-009 SHALL have port pkt_in  input  NUM_REQ x ring_packet_t  per-requester packet, stable while req high.
REQ-010 SHALL have port gnt  output  NUM_REQ  one-hot grant pulse, registered.
REQ-011 SHALL have port fifo_full  input  1  outbound ring FIFO full.
REQ-012 SHALL have port fifo_almost_full  input  1  outbound ring FIFO has exactly one free slot.
REQ-013 SHALL have port fifo_wrreq  output  1  outbound FIFO write, registered.
REQ-014 SHALL have port fifo_data  output  ring_packet_t  outbound FIFO data, registered.
REQ-015 SHALL have port starve_flag  output  NUM_REQ  requester currently promoted (zero when feature compiled out).

Function
REQ-016 SHALL arbitrate at each rising edge; winner i gives gnt[i]=1, fifo_wrreq=1, fifo_data=pkt_in[i] for exactly the following cycle (latency 1).
REQ-017 SHALL treat requester i as ineligible in any cycle where gnt[i] is high (requester drops req on the edge ending that cycle).
REQ-018 SHALL grant only when enable=1, fifo_full=0, and not (fifo_wrreq=1 and fifo_almost_full=1); otherwise gnt=0, fifo_wrreq=0.
REQ-019 SHALL use round-robin: search starts at index after last winner, wrapping NUM_REQ-1 -> 0; pointer updates only on a grant.
REQ-020 SHALL implement FSM IDLE/LOCKED with 4-bit lock counter: IDLE->LOCKED when winner has lock=1 (counter=1, owner=winner).
REQ-021 SHALL, in LOCKED, grant only the owner when owner req=1 and eligible; counter increments per owner grant.
REQ-022 SHALL return LOCKED->IDLE when owner grant issued with lock=0, owner req=0 at an arbitration edge outside its gnt cycle, or counter reaches LOCK_LIMIT (that grant is last; owner re-enters round-robin).
REQ-023 SHALL hold FSM state and counter unchanged while grants are blocked by REQ-018.
REQ-024 SHALL hold fifo_data at its last value when fifo_wrreq=0.
REQ-025 SHALL hold at most one grant outstanding; gnt always zero or one-hot.

Reset
REQ-026 SHALL, while reset_n=0, force gnt=0, fifo_wrreq=0, fifo_data='0, starve_flag=0, FSM=IDLE, lock counter=0, RR pointer so index 0 wins first, wait counters=0.
REQ-027 SHALL abort a lock on reset mid-operation; no grant issued on the first edge after reset_n rises unless REQ-018 holds.

Configuration
REQ-028 SHALL compile starvation promotion in with macro RING_ARB_STARVATION_EN.
REQ-029 SHALL, with RING_ARB_STARVATION_EN defined, keep per-requester 8-bit saturating wait counter (increments when req=1 and not granted, clears on grant or req=0); count>=STARVE_LIMIT sets starve_flag[i].
REQ-030 SHALL, with RING_ARB_STARVATION_EN defined, grant promoted requesters before round-robin and before a lock owner (lowest index among promoted wins); preemption forces LOCKED->IDLE.
REQ-031 SHALL, without RING_ARB_STARVATION_EN, contain no wait counters, tie starve_flag to 0, and use REQ-019..REQ-022 only.

Verification
REQ-032 SHALL cover: req=4'b1111 held, lock=0, FIFO empty -> gnt sequence 0,1,2,3,0 on alternate cycles per REQ-017, fifo_data matches pkt_in.
REQ-033 SHALL cover: req[2]=1 lock[2]=1 continuously, req[0]=1, LOCK_LIMIT=4 -> four grants to 2, then grant to 0.
REQ-034 SHALL cover: fifo_almost_full=1 with write in flight -> no grant next cycle; fifo_full=1 for 10 cycles -> zero writes, FSM held.
REQ-035 SHALL cover: with RING_ARB_STARVATION_EN, STARVE_LIMIT=16, requester 1 locked, requester 3 waiting 16 cycles -> starve_flag[3]=1, next grant to 3, lock dropped.
REQ-036 SHALL cover: reset_n pulsed low during LOCKED with gnt high -> gnt, fifo_wrreq cleared asynchronously; first post-reset grant goes to lowest requesting index.
